// File: rtl/rvc_fetch_aligner.sv
// rvc_fetch_aligner: splits fetch words into 16-bit parcels, then realigns them
// into mixed 16/32-bit RISC-V instructions with PC and compressed register fields.
//
// Core state
//   parcel queue | circular buffer of 16-bit parcels (head/tail/count)
//   pc           | PC of the next instruction to be loaded into the output register
//   drop         | low parcels of the next accepted word that precede the target PC
//   output reg   | one instruction held for decode until out_ready
module rvc_fetch_aligner #(
   parameter int              FETCH_W  = 32,
   parameter int              QDEPTH   = 8,
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic [XLEN-1:0]    flush_pc,
   input  logic               fetch_valid,
   output logic               fetch_ready,
   input  logic [FETCH_W-1:0] fetch_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_instr,
   output logic               out_is_comp,
   output logic [XLEN-1:0]    out_pc,
   output logic [2:0]         out_rdp,
   output logic [2:0]         out_rs2p
);

   localparam int PARCELS = FETCH_W / 16;
   localparam int PW      = $clog2(QDEPTH);
   localparam int CW      = $clog2(QDEPTH + 1);
   localparam int DW      = $clog2(PARCELS);

   logic [15:0]      mem_q [QDEPTH];
   logic [15:0]      mem_d [QDEPTH];
   logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]    count_q, count_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   logic [DW-1:0]    drop_q, drop_d;

   logic             out_valid_q, out_valid_d;
   logic [31:0]      out_instr_q, out_instr_d;
   logic             out_is_comp_q, out_is_comp_d;
   logic [XLEN-1:0]  out_pc_q, out_pc_d;
   logic [2:0]       out_rdp_q, out_rdp_d;
   logic [2:0]       out_rs2p_q, out_rs2p_d;

   logic [15:0]      head0, head1;
   logic             head_is32, avail, space_ok, push, load;
   logic [CW-1:0]    push_n, pop_n;
   logic             unused_flush_lsb;

   assign unused_flush_lsb = flush_pc[0];

   assign head0     = mem_q[head_q];
   assign head1     = mem_q[head_q + PW'(1)];
   assign head_is32 = (head0[1:0] == 2'b11);
   // A 32-bit head with only its low half buffered stalls until the next word.
   assign avail     = head_is32 ? (count_q >= CW'(2)) : (count_q != '0);

   // Registered count only: a pop in this cycle does not make room for a push.
   assign space_ok    = (32'(count_q) + 32'(PARCELS)) <= 32'(QDEPTH);
   assign fetch_ready = rst_n && !flush && space_ok;

   assign push   = fetch_valid && fetch_ready;
   assign load   = (!out_valid_q || out_ready) && avail;
   assign push_n = CW'(PARCELS) - CW'(drop_q);
   assign pop_n  = load ? (head_is32 ? CW'(2) : CW'(1)) : '0;

   // Queue, PC and drop next-state; flush overrides any push or pop.
   always_comb begin
      mem_d   = mem_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         pc_d    = {flush_pc[XLEN-1:1], 1'b0};
         drop_d  = flush_pc[DW:1];
      end else begin
         if (push) begin
            for (int i = 0; i < PARCELS; i++) begin
               if (i >= int'(drop_q))
                  mem_d[tail_q + PW'(i) - PW'(drop_q)] = fetch_data[16*i +: 16];
            end
            tail_d = tail_q + PW'(push_n);
            drop_d = '0;
         end
         if (load) begin
            head_d = head_q + PW'(pop_n);
            pc_d   = pc_q + (head_is32 ? XLEN'(4) : XLEN'(2));
         end
         count_d = count_q + (push ? push_n : '0) - pop_n;
      end
   end

   // Output register next-state; contents freeze while decode applies backpressure.
   always_comb begin
      out_valid_d   = out_valid_q;
      out_instr_d   = out_instr_q;
      out_is_comp_d = out_is_comp_q;
      out_pc_d      = out_pc_q;
      out_rdp_d     = out_rdp_q;
      out_rs2p_d    = out_rs2p_q;
      if (flush) begin
         out_valid_d   = 1'b0;
         out_instr_d   = '0;
         out_is_comp_d = 1'b0;
         out_pc_d      = '0;
         out_rdp_d     = '0;
         out_rs2p_d    = '0;
      end else if (load) begin
         out_valid_d   = 1'b1;
         out_instr_d   = head_is32 ? {head1, head0} : {16'h0000, head0};
         out_is_comp_d = !head_is32;
         out_pc_d      = pc_q;
         out_rdp_d     = head_is32 ? 3'b000 : head0[9:7];
         out_rs2p_d    = head_is32 ? 3'b000 : head0[4:2];
      end else if (out_ready) begin
         out_valid_d   = 1'b0;
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < QDEPTH; i++) mem_q[i] <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         count_q       <= '0;
         pc_q          <= {RESET_PC[XLEN-1:1], 1'b0};
         drop_q        <= RESET_PC[DW:1];
         out_valid_q   <= 1'b0;
         out_instr_q   <= '0;
         out_is_comp_q <= 1'b0;
         out_pc_q      <= '0;
         out_rdp_q     <= '0;
         out_rs2p_q    <= '0;
      end else begin
         mem_q         <= mem_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         count_q       <= count_d;
         pc_q          <= pc_d;
         drop_q        <= drop_d;
         out_valid_q   <= out_valid_d;
         out_instr_q   <= out_instr_d;
         out_is_comp_q <= out_is_comp_d;
         out_pc_q      <= out_pc_d;
         out_rdp_q     <= out_rdp_d;
         out_rs2p_q    <= out_rs2p_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_instr   = out_instr_q;
   assign out_is_comp = out_is_comp_q;
   assign out_pc      = out_pc_q;
   assign out_rdp     = out_rdp_q;
   assign out_rs2p    = out_rs2p_q;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Testbench for rvc_fetch_aligner: directed scenarios on 32- and 64-bit fetch
// instances plus a randomized run against a parcel-stream reference model.
module tb_rvc_fetch_aligner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // 32-bit fetch instance
   logic        flush = 0, fetch_valid = 0, out_ready = 0;
   logic [31:0] flush_pc = '0, fetch_data = '0;
   logic        fetch_ready, out_valid, out_is_comp;
   logic [31:0] out_instr, out_pc;
   logic [2:0]  out_rdp, out_rs2p;

   // 64-bit fetch instance
   logic        flush_w = 0, fetch_valid_w = 0, out_ready_w = 0;
   logic [31:0] flush_pc_w = '0;
   logic [63:0] fetch_data_w = '0;
   logic        fetch_ready_w, out_valid_w, out_is_comp_w;
   logic [31:0] out_instr_w, out_pc_w;
   logic [2:0]  out_rdp_w, out_rs2p_w;

   rvc_fetch_aligner #(.FETCH_W(32), .QDEPTH(8), .XLEN(32), .RESET_PC(32'h0)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
      .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_data(fetch_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_is_comp(out_is_comp), .out_pc(out_pc), .out_rdp(out_rdp), .out_rs2p(out_rs2p));

   rvc_fetch_aligner #(.FETCH_W(64), .QDEPTH(8), .XLEN(32), .RESET_PC(32'h0)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush_w), .flush_pc(flush_pc_w),
      .fetch_valid(fetch_valid_w), .fetch_ready(fetch_ready_w), .fetch_data(fetch_data_w),
      .out_valid(out_valid_w), .out_ready(out_ready_w), .out_instr(out_instr_w),
      .out_is_comp(out_is_comp_w), .out_pc(out_pc_w), .out_rdp(out_rdp_w), .out_rs2p(out_rs2p_w));

   int checks = 0;
   int errors = 0;

   logic [31:0] obs_instr[$];
   logic [31:0] obs_pc[$];
   logic        obs_comp[$];
   logic [2:0]  obs_rdp[$];
   logic [2:0]  obs_rs2p[$];

   // One cycle on the 32-bit instance; entered and left at posedge+1.
   // Records every completed output handshake outside of flush cycles.
   task automatic step(input bit fv, input logic [31:0] fd, input bit orr,
                       input bit fl, input logic [31:0] fpc, output bit acc);
      fetch_valid = fv; fetch_data = fd; out_ready = orr; flush = fl; flush_pc = fpc;
      #1;
      acc = fv && fetch_ready;
      if (out_valid && orr && !fl) begin
         obs_instr.push_back(out_instr);
         obs_pc.push_back(out_pc);
         obs_comp.push_back(out_is_comp);
         obs_rdp.push_back(out_rdp);
         obs_rs2p.push_back(out_rs2p);
      end
      @(posedge clk); #1;
   endtask

   task automatic clear_obs();
      obs_instr.delete(); obs_pc.delete(); obs_comp.delete();
      obs_rdp.delete(); obs_rs2p.delete();
   endtask

   task automatic test_reset();
      bit acc;
      #12;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL reset_fetch_ready: got %b want 0", fetch_ready); end
      checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
      checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      step(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL reset_ready_after_release: got %b want 1", acc); end
      // Drain that word so later tests start from a clean, known queue.
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
   endtask

   task automatic test_basic();
      bit acc;
      clear_obs();
      step(1'b1, 32'hc14c_05ad, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b want 1", acc); end
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 2) begin errors++; $display("FAIL basic_count: got %0d want 2", obs_instr.size()); end
      if (obs_instr.size() >= 2) begin
         checks++; if (obs_instr[0] !== 32'h0000_05ad || obs_pc[0] !== 32'h0) begin errors++;
            $display("FAIL basic_first: got %h@%h want 000005ad@0", obs_instr[0], obs_pc[0]); end
         checks++; if (obs_comp[0] !== 1'b1 || obs_rdp[0] !== 3'd3 || obs_rs2p[0] !== 3'd3) begin errors++;
            $display("FAIL basic_fields: got comp=%b rdp=%0d rs2p=%0d want 1 3 3", obs_comp[0], obs_rdp[0], obs_rs2p[0]); end
         checks++; if (obs_instr[1] !== 32'h0000_c14c || obs_pc[1] !== 32'h2) begin errors++;
            $display("FAIL basic_second: got %h@%h want 0000c14c@2", obs_instr[1], obs_pc[1]); end
      end
   endtask

   task automatic test_straddle();
      bit acc;
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      clear_obs();
      step(1'b1, 32'h0513_05ad, 1'b1, 1'b0, 32'h0, acc);
      for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 1) begin errors++; $display("FAIL straddle_stall: got %0d outputs want 1", obs_instr.size()); end
      step(1'b1, 32'h8605_00a5, 1'b1, 1'b0, 32'h0, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 3) begin errors++; $display("FAIL straddle_count: got %0d want 3", obs_instr.size()); end
      if (obs_instr.size() >= 3) begin
         checks++; if (obs_instr[0] !== 32'h0000_05ad || obs_pc[0] !== 32'h0) begin errors++;
            $display("FAIL straddle_first: got %h@%h want 000005ad@0", obs_instr[0], obs_pc[0]); end
         checks++; if (obs_instr[1] !== 32'h00a5_0513 || obs_pc[1] !== 32'h2 || obs_comp[1] !== 1'b0
                       || obs_rdp[1] !== 3'd0 || obs_rs2p[1] !== 3'd0) begin errors++;
            $display("FAIL straddle_wide: got %h@%h comp=%b rdp=%0d rs2p=%0d want 00a50513@2 0 0 0",
                     obs_instr[1], obs_pc[1], obs_comp[1], obs_rdp[1], obs_rs2p[1]); end
         checks++; if (obs_instr[2] !== 32'h0000_8605 || obs_pc[2] !== 32'h6 || obs_rdp[2] !== 3'd4
                       || obs_rs2p[2] !== 3'd1) begin errors++;
            $display("FAIL straddle_third: got %h@%h rdp=%0d rs2p=%0d want 00008605@6 4 1",
                     obs_instr[2], obs_pc[2], obs_rdp[2], obs_rs2p[2]); end
      end
   endtask

   task automatic test_flush();
      bit acc;
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      clear_obs();
      step(1'b1, 32'h0001_0001, 1'b0, 1'b0, 32'h0, acc);
      for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_inflight: got out_valid=%b want 1", out_valid); end
      step(1'b1, 32'h1234_5679, 1'b1, 1'b1, 32'h0000_0102, acc);
      checks++; if (acc !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got accept=%b want 0", acc); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clears_valid: got %b want 0", out_valid); end
      step(1'b1, 32'h4a80_c910, 1'b1, 1'b0, 32'h0, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 1) begin errors++; $display("FAIL flush_count: got %0d want 1", obs_instr.size()); end
      if (obs_instr.size() >= 1) begin
         checks++; if (obs_instr[0] !== 32'h0000_4a80 || obs_pc[0] !== 32'h102) begin errors++;
            $display("FAIL flush_target: got %h@%h want 00004a80@102", obs_instr[0], obs_pc[0]); end
      end
   endtask

   task automatic test_backpressure();
      bit acc, refused;
      int accepted, late_accept, unstable;
      logic [15:0] p0, p1;
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      clear_obs();
      accepted = 0; late_accept = 0; unstable = 0; refused = 0;
      for (int k = 0; k < 12; k++) begin
         p0 = 16'((2*accepted) * 4 + 1);
         p1 = 16'((2*accepted + 1) * 4 + 1);
         step(1'b1, {p1, p0}, 1'b0, 1'b0, 32'h0, acc);
         if (acc) begin
            accepted++;
            if (refused) late_accept++;
         end else refused = 1;
         if (out_valid && (out_instr !== 32'h1 || out_pc !== 32'h0)) unstable++;
      end
      checks++; if (accepted != 4) begin errors++; $display("FAIL bp_accepted_words: got %0d want 4", accepted); end
      checks++; if (late_accept != 0) begin errors++; $display("FAIL bp_ready_reasserted: got %0d late accepts want 0", late_accept); end
      checks++; if (out_valid !== 1'b1 || unstable != 0) begin errors++;
         $display("FAIL bp_hold_stable: got valid=%b unstable=%0d want 1 0", out_valid, unstable); end
      for (int k = 0; k < 14; k++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 8) begin errors++; $display("FAIL bp_drain_count: got %0d want 8", obs_instr.size()); end
      for (int i = 0; i < obs_instr.size() && i < 8; i++) begin
         checks++;
         if (obs_instr[i] !== 32'(i*4 + 1) || obs_pc[i] !== 32'(2*i)) begin errors++;
            $display("FAIL bp_drain_%0d: got %h@%h want %h@%h", i, obs_instr[i], obs_pc[i], 32'(i*4+1), 32'(2*i)); end
      end
   endtask

   task automatic test_wide_fetch();
      logic [63:0] word;
      logic [31:0] exp_i[$], exp_p[$], got_i[$], got_p[$];
      int drop;
      bit acc;
      word = 64'h8c69_4a80_40c8_8605;
      drop = 2;  // target 0x4 sits two parcels into its 8-byte fetch word
      for (int i = drop; i < 4; i++) begin
         exp_i.push_back({16'h0, word[16*i +: 16]});
         exp_p.push_back(32'h4 + 32'(2*(i - drop)));
      end
      out_ready_w = 1; flush_w = 1; flush_pc_w = 32'h4;
      @(posedge clk); #1;
      flush_w = 0; fetch_valid_w = 1; fetch_data_w = word;
      #1; acc = fetch_ready_w;
      @(posedge clk); #1;
      fetch_valid_w = 0;
      checks++; if (acc !== 1'b1) begin errors++; $display("FAIL wide_accept: got %b want 1", acc); end
      for (int c = 0; c < 10; c++) begin
         #1;
         if (out_valid_w && out_ready_w) begin got_i.push_back(out_instr_w); got_p.push_back(out_pc_w); end
         @(posedge clk); #1;
      end
      checks++; if (got_i.size() != exp_i.size()) begin errors++;
         $display("FAIL wide_count: got %0d want %0d", got_i.size(), exp_i.size()); end
      for (int i = 0; i < got_i.size() && i < exp_i.size(); i++) begin
         checks++;
         if (got_i[i] !== exp_i[i] || got_p[i] !== exp_p[i]) begin errors++;
            $display("FAIL wide_%0d: got %h@%h want %h@%h", i, got_i[i], got_p[i], exp_i[i], exp_p[i]); end
      end
   endtask

   task automatic test_reset_midstream();
      bit acc;
      step(1'b0, 32'h0, 1'b1, 1'b1, 32'h0, acc);
      step(1'b1, 32'h0009_0005, 1'b0, 1'b0, 32'h0, acc);
      step(1'b1, 32'h0011_000d, 1'b0, 1'b0, 32'h0, acc);
      step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, acc);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_setup: got out_valid=%b want 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0 || fetch_ready !== 1'b0 || out_instr !== 32'h0) begin errors++;
         $display("FAIL rst_mid_async: got valid=%b ready=%b instr=%h want 0 0 0", out_valid, fetch_ready, out_instr); end
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      clear_obs();
      step(1'b1, 32'h0019_0015, 1'b1, 1'b0, 32'h0, acc);
      for (int i = 0; i < 6; i++) step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, acc);
      checks++; if (obs_instr.size() != 2) begin errors++; $display("FAIL rst_mid_count: got %0d want 2", obs_instr.size()); end
      if (obs_instr.size() >= 1) begin
         checks++; if (obs_instr[0] !== 32'h15 || obs_pc[0] !== 32'h0) begin errors++;
            $display("FAIL rst_mid_first: got %h@%h want 00000015@0", obs_instr[0], obs_pc[0]); end
      end
   endtask

   // Randomized traffic; the model is a plain parcel stream consumed by decode.
   task automatic test_random();
      logic [15:0] mq[$];
      logic [31:0] mpc, exp_instr, fd, fpc, h_instr, h_pc;
      logic [2:0]  exp_rdp, exp_rs2p;
      bit          fv, orr, fl, acc, hs, hold, h_valid, exp_comp;
      int          mdrop;
      hold = 0; mpc = 0; mdrop = 0; h_instr = 0; h_pc = 0; h_valid = 0;
      for (int cyc = 0; cyc < 830; cyc++) begin
         fd  = $urandom;
         fpc = (($urandom_range(0, 3) == 0) ? 32'hffff_fff0 : 32'h0) | ($urandom & 32'h0000_0ffe) | 32'($urandom_range(0, 1));
         if (cyc < 800) begin
            fv  = ($urandom_range(0, 99) < 70);
            orr = ($urandom_range(0, 99) < 60);
            fl  = (cyc == 0) || ($urandom_range(0, 99) < 3);
         end else begin
            fv = 0; orr = 1; fl = 0;
         end
         fetch_valid = fv; fetch_data = fd; out_ready = orr; flush = fl; flush_pc = fpc;
         #1;
         acc = fv && fetch_ready;
         hs  = out_valid && orr;
         if (hold) begin
            checks++;
            if (out_valid !== h_valid || out_instr !== h_instr || out_pc !== h_pc) begin errors++;
               $display("FAIL rnd_stable cyc %0d: got %b %h@%h want %b %h@%h", cyc, out_valid, out_instr, out_pc, h_valid, h_instr, h_pc); end
         end
         if (fl) begin
            checks++; if (fetch_ready !== 1'b0) begin errors++; $display("FAIL rnd_flush_ready cyc %0d: got %b want 0", cyc, fetch_ready); end
            mq.delete();
            mpc = fpc & ~32'h1;
            mdrop = int'(fpc[1]);
            hold = 0;
         end else begin
            if (hs) begin
               checks++;
               if (mq.size() == 0 || (mq[0][1:0] == 2'b11 && mq.size() < 2)) begin errors++;
                  $display("FAIL rnd_spurious cyc %0d: got %h@%h with %0d parcels buffered", cyc, out_instr, out_pc, mq.size());
               end else begin
                  exp_comp  = (mq[0][1:0] != 2'b11);
                  exp_instr = exp_comp ? {16'h0, mq[0]} : {mq[1], mq[0]};
                  exp_rdp   = exp_comp ? mq[0][9:7] : 3'd0;
                  exp_rs2p  = exp_comp ? mq[0][4:2] : 3'd0;
                  if (out_instr !== exp_instr || out_pc !== mpc || out_is_comp !== exp_comp
                      || out_rdp !== exp_rdp || out_rs2p !== exp_rs2p) begin errors++;
                     $display("FAIL rnd_out cyc %0d: got %h@%h c%b r%0d s%0d want %h@%h c%b r%0d s%0d", cyc,
                              out_instr, out_pc, out_is_comp, out_rdp, out_rs2p, exp_instr, mpc, exp_comp, exp_rdp, exp_rs2p);
                  end
                  void'(mq.pop_front());
                  if (!exp_comp) void'(mq.pop_front());
                  mpc = mpc + (exp_comp ? 32'd2 : 32'd4);
               end
            end
            if (acc) begin
               for (int i = mdrop; i < 2; i++) mq.push_back(fd[16*i +: 16]);
               mdrop = 0;
            end
            hold = out_valid && !orr;
            h_valid = out_valid; h_instr = out_instr; h_pc = out_pc;
         end
         @(posedge clk); #1;
      end
      checks++;
      if (!(mq.size() == 0 || (mq.size() == 1 && mq[0][1:0] == 2'b11))) begin errors++;
         $display("FAIL rnd_drain: got %0d parcels left undelivered want 0 or a lone upper-less half", mq.size()); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_straddle();
      test_flush();
      test_backpressure();
      test_wide_fetch();
      test_reset_midstream();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
